// File: rtl/irq_vector_ctrl.sv
// Vectored interrupt controller: level/edge sources, fixed priority (index 0 highest), in-service nesting.
// Avalon-MM slave, no wait states; readdata and irq_out are each registered with one cycle of latency.
module irq_vector_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSRC-1:0] irq_src,
    input  logic [2:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [15:0]     writedata,
    output logic [15:0]     readdata,
    output logic            irq_out
);

    localparam logic [2:0] A_PENDING = 3'd0;
    localparam logic [2:0] A_ENABLE  = 3'd1;
    localparam logic [2:0] A_MODE    = 3'd2;
    localparam logic [2:0] A_VECTOR  = 3'd3;
    localparam logic [2:0] A_ACK     = 3'd4;
    localparam logic [2:0] A_EOI     = 3'd5;

    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] edge_pend_q, edge_pend_d;
    logic [NSRC-1:0] insvc_q, insvc_d;
    logic [NSRC-1:0] src_q;
    logic [15:0]     readdata_q, readdata_d;
    logic            irq_q;

    logic [NSRC-1:0] rise, pending, active, edge_clr;
    logic [2:0]      best, cur, wr_idx;
    logic            preempt, wr_en, wr_idx_ok;
    logic            unused_wdata;

    function automatic logic [15:0] ext16(input logic [NSRC-1:0] v);
        logic [15:0] r;
        r = '0;
        r[NSRC-1:0] = v;
        return r;
    endfunction

    assign wr_en        = chipselect & ~write_n;
    assign wr_idx       = writedata[2:0];
    assign wr_idx_ok    = int'(wr_idx) < NSRC;
    assign rise         = irq_src & ~src_q;
    // Level sources bypass the latch entirely so they track the line.
    assign pending      = (mode_q & edge_pend_q) | (~mode_q & irq_src);
    assign active       = pending & enable_q;
    assign unused_wdata = ^writedata[15:NSRC];

    always_comb begin
        best = '0;
        cur  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i])  best = 3'(i);
            if (insvc_q[i]) cur  = 3'(i);
        end
        preempt = (|active) && ((insvc_q == '0) || (best < cur));
    end

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        insvc_d  = insvc_q;
        edge_clr = '0;
        if (wr_en) begin
            case (address)
                A_PENDING: edge_clr = writedata[NSRC-1:0];
                A_ENABLE:  enable_d = writedata[NSRC-1:0];
                A_MODE:    mode_d   = writedata[NSRC-1:0];
                A_ACK: begin
                    if (wr_idx_ok) begin
                        insvc_d[wr_idx]  = 1'b1;
                        edge_clr[wr_idx] = 1'b1;
                    end
                end
                A_EOI: begin
                    if (insvc_q != '0) insvc_d[cur] = 1'b0;
                end
                default: ;
            endcase
        end
        // A new rising edge outranks a same-cycle clear.
        edge_pend_d = (rise | (edge_pend_q & ~edge_clr)) & mode_q;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            A_PENDING: readdata_d = ext16(pending);
            A_ENABLE:  readdata_d = ext16(enable_q);
            A_MODE:    readdata_d = ext16(mode_q);
            A_VECTOR:  readdata_d = {preempt, 12'd0, best};
            A_ACK:     readdata_d = ext16(insvc_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q    <= '0;
            mode_q      <= '0;
            edge_pend_q <= '0;
            insvc_q     <= '0;
            src_q       <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            edge_pend_q <= edge_pend_d;
            insvc_q     <= insvc_d;
            src_q       <= irq_src;
            readdata_q  <= readdata_d;
            irq_q       <= preempt;
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_irq_vector_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  irq_src;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq_out;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] rd_val;

    irq_vector_ctrl #(.NSRC(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_src    (irq_src),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        irq_src    = '0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #12;
        chk("reset_readdata", readdata, 16'h0000);
        chk("reset_irq", {15'd0, irq_out}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Level source 0
        wr(3'd1, 16'h0001);
        irq_src = 8'h01;
        chk("lvl_irq_before_edge", {15'd0, irq_out}, 16'h0000);
        tick();
        chk("lvl_irq_set", {15'd0, irq_out}, 16'h0001);
        rd(3'd3, rd_val);
        chk("lvl_vector", rd_val, 16'h8000);
        rd(3'd1, rd_val);
        chk("lvl_enable_rd", rd_val, 16'h0001);
        irq_src = 8'h00;
        tick();
        chk("lvl_irq_clear", {15'd0, irq_out}, 16'h0000);

        // Edge source 1
        wr(3'd2, 16'h0002);
        wr(3'd1, 16'h0002);
        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        rd(3'd0, rd_val);
        chk("edge_pend_held", rd_val, 16'h0002);
        chk("edge_irq", {15'd0, irq_out}, 16'h0001);
        wr(3'd0, 16'h0002);
        rd(3'd0, rd_val);
        chk("edge_pend_cleared", rd_val, 16'h0000);
        chk("edge_irq_cleared", {15'd0, irq_out}, 16'h0000);
        irq_src = 8'h02;
        wr(3'd0, 16'h0002);
        irq_src = 8'h00;
        rd(3'd0, rd_val);
        chk("edge_set_wins", rd_val, 16'h0002);
        wr(3'd0, 16'h0002);
        wr(3'd2, 16'h0000);

        // Nesting with level sources 3 and 5
        wr(3'd1, 16'h00FF);
        irq_src = 8'h28;
        rd(3'd3, rd_val);
        chk("nest_vector_3", rd_val, 16'h8003);
        wr(3'd4, 16'h0003);
        rd(3'd4, rd_val);
        chk("nest_insvc_08", rd_val, 16'h0008);
        chk("nest_irq_masked", {15'd0, irq_out}, 16'h0000);
        irq_src = 8'h2A;
        rd(3'd3, rd_val);
        chk("nest_vector_1", rd_val, 16'h8001);
        chk("nest_irq_preempt", {15'd0, irq_out}, 16'h0001);

        // ACK / EOI unwinding
        wr(3'd4, 16'h0001);
        wr(3'd5, 16'h0000);
        rd(3'd4, rd_val);
        chk("eoi_insvc_08", rd_val, 16'h0008);
        rd(3'd5, rd_val);
        chk("eoi_read_zero", rd_val, 16'h0000);
        wr(3'd5, 16'h0000);
        rd(3'd4, rd_val);
        chk("eoi_insvc_00", rd_val, 16'h0000);
        chk("eoi_rearm_irq", {15'd0, irq_out}, 16'h0001);
        wr(3'd4, 16'h0007);
        rd(3'd4, rd_val);
        chk("ack7_insvc", rd_val, 16'h0080);
        wr(3'd5, 16'h0000);
        rd(3'd4, rd_val);
        chk("ack7_eoi_clean", rd_val, 16'h0000);
        wr(3'd5, 16'h0000);
        rd(3'd4, rd_val);
        chk("eoi_idle_noop", rd_val, 16'h0000);
        irq_src = 8'h00;

        // Disable keeps pending
        wr(3'd1, 16'h0004);
        irq_src = 8'h04;
        tick();
        chk("dis_irq_on", {15'd0, irq_out}, 16'h0001);
        wr(3'd1, 16'h0000);
        tick();
        chk("dis_irq_off", {15'd0, irq_out}, 16'h0000);
        rd(3'd0, rd_val);
        chk("dis_pending_kept", rd_val, 16'h0004);
        rd(3'd3, rd_val);
        chk("dis_vector_idle", rd_val, 16'h0000);
        wr(3'd1, 16'h0004);
        tick();
        chk("dis_reenable_irq", {15'd0, irq_out}, 16'h0001);
        irq_src = 8'h00;

        // Unused address
        wr(3'd6, 16'hFFFF);
        rd(3'd6, rd_val);
        chk("addr6_zero", rd_val, 16'h0000);
        rd(3'd1, rd_val);
        chk("addr6_no_side", rd_val, 16'h0004);

        // Reset mid-service
        wr(3'd2, 16'h0010);
        irq_src = 8'h10;
        tick();
        irq_src = 8'h00;
        wr(3'd4, 16'h0000);
        wr(3'd4, 16'h0001);
        wr(3'd1, 16'h00FF);
        rd(3'd4, rd_val);
        chk("pre_rst_insvc", rd_val, 16'h0003);
        rd(3'd0, rd_val);
        chk("pre_rst_pending", rd_val, 16'h0010);
        address = 3'd4;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_readdata", readdata, 16'h0000);
        chk("rst_irq", {15'd0, irq_out}, 16'h0000);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_irq", {15'd0, irq_out}, 16'h0000);
        rd(3'd4, rd_val);
        chk("post_rst_insvc", rd_val, 16'h0000);
        rd(3'd0, rd_val);
        chk("post_rst_pending", rd_val, 16'h0000);
        rd(3'd1, rd_val);
        chk("post_rst_enable", rd_val, 16'h0000);
        rd(3'd2, rd_val);
        chk("post_rst_mode", rd_val, 16'h0000);

        // Source held high across reset, then switched to edge mode
        reset_n = 1'b0;
        irq_src = 8'h04;
        tick();
        reset_n = 1'b1;
        tick();
        wr(3'd2, 16'h0004);
        rd(3'd0, rd_val);
        chk("held_no_rise", rd_val, 16'h0000);
        irq_src = 8'h00;
        tick();
        irq_src = 8'h04;
        tick();
        rd(3'd0, rd_val);
        chk("held_new_rise", rd_val, 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
